// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: sequencer states, default width
// and the parity helper used by both the adder and the serial subtractor.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned PARITY_W      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 1 when v holds an even number of ones; zero-extension keeps the count.
    function automatic logic even_parity(input logic [PARITY_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial two's-complement subtractor z = x - y, LSB first, with
// start/busy/done handshake and adder-compatible status flags.
module serial_sub16
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             parity,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             x_msb;
    logic             y_msb;
    logic             d;
    logic             bout;
    logic             last;
    logic             load;
    logic             step;
    logic             publish;
    logic [WIDTH-1:0] z_new;

    full_sub_bit u_bit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    assign last  = (cnt == CW'(WIDTH - 1));
    assign z_new = {d, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath strobes; a start in DONE is accepted exactly as in IDLE.
    always_comb begin
        load    = 1'b0;
        step    = 1'b0;
        publish = 1'b0;
        case (state)
            IDLE:    load = start;
            RUN: begin
                step    = 1'b1;
                publish = last;
            end
            DONE:    load = start;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            cnt      <= '0;
            bin      <= 1'b0;
            x_msb    <= 1'b0;
            y_msb    <= 1'b0;
            z        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            parity   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load) begin
                a_sr  <= x;
                b_sr  <= y;
                cnt   <= '0;
                bin   <= 1'b0;
                x_msb <= x[WIDTH-1];
                y_msb <= y[WIDTH-1];
            end else if (step) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= z_new;
                cnt  <= cnt + CW'(1);
                bin  <= bout;
            end
            // Flags come from the complete result and the latched operand MSBs.
            if (publish) begin
                z        <= z_new;
                sign     <= z_new[WIDTH-1];
                zero     <= (z_new == '0);
                overflow <= (x_msb != y_msb) && (z_new[WIDTH-1] != x_msb);
                carry    <= bout;
                parity   <= even_parity(PARITY_W'(z_new));
            end
            busy <= (state_n == RUN);
            done <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_serial_sub16.sv
// Directed and random checks of serial_sub16 against an arithmetic reference.
module tb_serial_sub16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        overflow;
    logic        carry;
    logic        parity;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] z;
        logic        sign;
        logic        zero;
        logic        overflow;
        logic        carry;
        logic        parity;
    } res_t;

    res_t pub;

    serial_sub16 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .y        (y),
        .z        (z),
        .sign     (sign),
        .zero     (zero),
        .overflow (overflow),
        .carry    (carry),
        .parity   (parity),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t r;
        int   sd;
        r.z        = a - b;
        r.carry    = (a < b);
        r.sign     = r.z[15];
        r.zero     = (r.z == 16'd0);
        sd         = int'($signed(a)) - int'($signed(b));
        r.overflow = (sd > 32767) || (sd < -32768);
        r.parity   = (($countones(r.z) % 2) == 0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, ".z"},        32'(z),        32'(e.z));
        check({tag, ".sign"},     32'(sign),     32'(e.sign));
        check({tag, ".zero"},     32'(zero),     32'(e.zero));
        check({tag, ".overflow"}, 32'(overflow), 32'(e.overflow));
        check({tag, ".carry"},    32'(carry),    32'(e.carry));
        check({tag, ".parity"},   32'(parity),   32'(e.parity));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from idle; junk operands and a stray start arrive while busy.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        int   n;
        bit   seen;
        res_t e;
        e     = model(a, b);
        x     = a;
        y     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        x     = 16'($urandom);
        y     = 16'($urandom);
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 40) begin
            if (n == 4) start = 1'b1;
            if (n == 5) start = 1'b0;
            if (n == 8) begin
                check({tag, ".busy_mid"}, 32'(busy), 32'd1);
                check({tag, ".hold_mid"}, 32'(z), 32'(pub.z));
            end
            tick();
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, ".latency"}, 32'(n), 32'd16);
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check_res(tag, e);
        pub = e;
        tick();
        check({tag, ".pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] ax;
        logic [15:0] ay;
        bit          any_done;

        rst   = 1'b1;
        start = 1'b0;
        x     = 16'h0;
        y     = 16'h0;
        pub   = '0;
        tick();
        tick();
        rst = 1'b0;
        check_res("reset", pub);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);

        run_op("v1", 16'h8fff, 16'h8000);
        run_op("v2", 16'h0000, 16'h0002);
        run_op("v3", 16'h8000, 16'h0001);
        run_op("v4", 16'h5555, 16'h5555);
        run_op("v5", 16'h7fff, 16'hffff);
        run_op("v6", 16'hffff, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            run_op("rnd", 16'($urandom), 16'($urandom));
        end

        // Abort mid-operation with reset.
        x     = 16'h0001;
        y     = 16'h0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pub = '0;
        check_res("abort", pub);
        check("abort.busy", 32'(busy), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done !== 1'b0) any_done = 1'b1;
        end
        check("abort.no_done", 32'(any_done), 32'd0);
        run_op("after_abort", 16'h0003, 16'h0001);

        // Start held high with fresh operands every cycle.
        ax    = 16'h0;
        ay    = 16'h0;
        start = 1'b1;
        for (int n = 0; n < 68; n++) begin
            logic [15:0] cx;
            logic [15:0] cy;
            cx = 16'($urandom);
            cy = 16'($urandom);
            x  = cx;
            y  = cy;
            @(posedge clk);
            if (n % 17 == 0) begin
                ax = cx;
                ay = cy;
            end
            #1;
            if (n % 17 == 16) begin
                pub = model(ax, ay);
                check("b2b.done", 32'(done), 32'd1);
                check_res("b2b", pub);
            end else begin
                check("b2b.nodone", 32'(done), 32'd0);
                check("b2b.stable", 32'(z), 32'(pub.z));
            end
        end
        start = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_sub16.md
# serial_sub16

Bit-serial two's-complement subtractor that computes z = x − y one bit per clock, LSB first. It reports the same five status flags as the combinational 16-bit adder: sign, zero, overflow, carry and parity. It is the inverse-operation companion to that adder and sits alongside it in the arithmetic datapath, trading latency for a single 1-bit subtract cell. A start/busy/done handshake sequences it.

## Interface
- WIDTH, 16, operand and result width in bits; all flag rules below use WIDTH−1 as the sign bit.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- x  input  WIDTH  minuend; sampled on the edge that accepts start.
- y  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- z  output  WIDTH  result x − y mod 2^WIDTH.
- sign  output  1  z[WIDTH−1].
- zero  output  1  1 when z == 0.
- overflow  output  1  signed overflow: (x[MSB] != y[MSB]) && (z[MSB] != x[MSB]).
- carry  output  1  borrow out; 1 iff x < y unsigned.
- parity  output  1  1 when z has an even number of ones.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when z and the flags are updated.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch x, y into shift registers; clear the bit counter; set the borrow register to 0; go to RUN.
- RUN: each cycle computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin) on the operand LSBs. Both operand registers shift right, and d shifts into the result register from the MSB end. The counter increments.
  - After WIDTH bits: publish z, all flags and carry = final bout; go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in this cycle → accepted as in IDLE; go to RUN (back-to-back).
  - Otherwise go to IDLE.
- z and the flags hold their previous values throughout RUN. They change only on the publishing edge and hold until the next publish or reset.
- start while busy=1 is ignored; no queuing.
- Flags are derived from the final result and the latched operand MSBs, never from partial results.

## Timing
- Reset: state IDLE. z=0, sign=0, zero=0, overflow=0, carry=0, parity=0, busy=0, done=0. Counter, borrow and shift registers are cleared.
- rst has priority over start in the same cycle.
- rst during RUN aborts the operation and clears all outputs; the partial result is discarded.
- Accepting edge = E0. busy=1 from after E0 through the edge E0+WIDTH. The publish edge is E0+WIDTH.
- done=1 and busy=0 in the cycle after E0+WIDTH.
- Latency: start accepted to done high is WIDTH+1 edges (17 at default).
- Back-to-back throughput: one result per WIDTH+1 cycles.
- Counter width: $clog2(WIDTH+1). The counter must not wrap within an operation.

## Structure
- Shared package arith_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - DEFAULT_WIDTH = 16;
  - a parity helper function, shared with the adder flag logic.
- Sub-module full_sub_bit: 1-bit full subtractor with inputs a, b, bin and outputs d, bout. It is instantiated once; all sequencing stays in serial_sub16.

## Test plan
- x=0x8fff, y=0x8000, start → after 17 cycles: done pulse; z=0x0fff, sign=0, zero=0, overflow=0, carry=0, parity=1.
- x=0x0000, y=0x0002 → z=0xfffe, sign=1, zero=0, overflow=0, carry=1, parity=0.
- x=0x8000, y=0x0001 → z=0x7fff, sign=0, overflow=1, carry=0, parity=0.
- x=0x5555, y=0x5555 → z=0x0000, zero=1, parity=1, sign=0, overflow=0, carry=0.
- Start x=0x0001, y=0x0001; assert rst one cycle after 8 RUN cycles → all outputs 0, busy=0, no done pulse. A new start with x=0x0003, y=0x0001 then gives z=0x0002 after 17 cycles.
- Hold start high continuously with new operands each cycle:
  - operands presented while busy are ignored;
  - start is re-accepted in the DONE cycle;
  - done pulses exactly every 17 cycles;
  - z and the flags stay stable between pulses.
